// File: rtl/des_pkg.sv
// DES constants, bit-numbering helpers and the table-driven permutations
// shared by the decryption core and its round function.
package des_pkg;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ROUND = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

    // Decryption walks the key schedule backwards: round 1 reuses C0||D0 (K16).
    localparam logic [1:0] RS [16] = '{
        2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

    // Entry index is {b6, b1, b5..b2} of the 6-bit S-box input (row-major).
    localparam logic [3:0] SBOX [8][64] = '{
        '{4'd14, 4'd4, 4'd13, 4'd1, 4'd2, 4'd15, 4'd11, 4'd8, 4'd3, 4'd10, 4'd6, 4'd12, 4'd5, 4'd9, 4'd0, 4'd7,
          4'd0, 4'd15, 4'd7, 4'd4, 4'd14, 4'd2, 4'd13, 4'd1, 4'd10, 4'd6, 4'd12, 4'd11, 4'd9, 4'd5, 4'd3, 4'd8,
          4'd4, 4'd1, 4'd14, 4'd8, 4'd13, 4'd6, 4'd2, 4'd11, 4'd15, 4'd12, 4'd9, 4'd7, 4'd3, 4'd10, 4'd5, 4'd0,
          4'd15, 4'd12, 4'd8, 4'd2, 4'd4, 4'd9, 4'd1, 4'd7, 4'd5, 4'd11, 4'd3, 4'd14, 4'd10, 4'd0, 4'd6, 4'd13},
        '{4'd15, 4'd1, 4'd8, 4'd14, 4'd6, 4'd11, 4'd3, 4'd4, 4'd9, 4'd7, 4'd2, 4'd13, 4'd12, 4'd0, 4'd5, 4'd10,
          4'd3, 4'd13, 4'd4, 4'd7, 4'd15, 4'd2, 4'd8, 4'd14, 4'd12, 4'd0, 4'd1, 4'd10, 4'd6, 4'd9, 4'd11, 4'd5,
          4'd0, 4'd14, 4'd7, 4'd11, 4'd10, 4'd4, 4'd13, 4'd1, 4'd5, 4'd8, 4'd12, 4'd6, 4'd9, 4'd3, 4'd2, 4'd15,
          4'd13, 4'd8, 4'd10, 4'd1, 4'd3, 4'd15, 4'd4, 4'd2, 4'd11, 4'd6, 4'd7, 4'd12, 4'd0, 4'd5, 4'd14, 4'd9},
        '{4'd10, 4'd0, 4'd9, 4'd14, 4'd6, 4'd3, 4'd15, 4'd5, 4'd1, 4'd13, 4'd12, 4'd7, 4'd11, 4'd4, 4'd2, 4'd8,
          4'd13, 4'd7, 4'd0, 4'd9, 4'd3, 4'd4, 4'd6, 4'd10, 4'd2, 4'd8, 4'd5, 4'd14, 4'd12, 4'd11, 4'd15, 4'd1,
          4'd13, 4'd6, 4'd4, 4'd9, 4'd8, 4'd15, 4'd3, 4'd0, 4'd11, 4'd1, 4'd2, 4'd12, 4'd5, 4'd10, 4'd14, 4'd7,
          4'd1, 4'd10, 4'd13, 4'd0, 4'd6, 4'd9, 4'd8, 4'd7, 4'd4, 4'd15, 4'd14, 4'd3, 4'd11, 4'd5, 4'd2, 4'd12},
        '{4'd7, 4'd13, 4'd14, 4'd3, 4'd0, 4'd6, 4'd9, 4'd10, 4'd1, 4'd2, 4'd8, 4'd5, 4'd11, 4'd12, 4'd4, 4'd15,
          4'd13, 4'd8, 4'd11, 4'd5, 4'd6, 4'd15, 4'd0, 4'd3, 4'd4, 4'd7, 4'd2, 4'd12, 4'd1, 4'd10, 4'd14, 4'd9,
          4'd10, 4'd6, 4'd9, 4'd0, 4'd12, 4'd11, 4'd7, 4'd13, 4'd15, 4'd1, 4'd3, 4'd14, 4'd5, 4'd2, 4'd8, 4'd4,
          4'd3, 4'd15, 4'd0, 4'd6, 4'd10, 4'd1, 4'd13, 4'd8, 4'd9, 4'd4, 4'd5, 4'd11, 4'd12, 4'd7, 4'd2, 4'd14},
        '{4'd2, 4'd12, 4'd4, 4'd1, 4'd7, 4'd10, 4'd11, 4'd6, 4'd8, 4'd5, 4'd3, 4'd15, 4'd13, 4'd0, 4'd14, 4'd9,
          4'd14, 4'd11, 4'd2, 4'd12, 4'd4, 4'd7, 4'd13, 4'd1, 4'd5, 4'd0, 4'd15, 4'd10, 4'd3, 4'd9, 4'd8, 4'd6,
          4'd4, 4'd2, 4'd1, 4'd11, 4'd10, 4'd13, 4'd7, 4'd8, 4'd15, 4'd9, 4'd12, 4'd5, 4'd6, 4'd3, 4'd0, 4'd14,
          4'd11, 4'd8, 4'd12, 4'd7, 4'd1, 4'd14, 4'd2, 4'd13, 4'd6, 4'd15, 4'd0, 4'd9, 4'd10, 4'd4, 4'd5, 4'd3},
        '{4'd12, 4'd1, 4'd10, 4'd15, 4'd9, 4'd2, 4'd6, 4'd8, 4'd0, 4'd13, 4'd3, 4'd4, 4'd14, 4'd7, 4'd5, 4'd11,
          4'd10, 4'd15, 4'd4, 4'd2, 4'd7, 4'd12, 4'd9, 4'd5, 4'd6, 4'd1, 4'd13, 4'd14, 4'd0, 4'd11, 4'd3, 4'd8,
          4'd9, 4'd14, 4'd15, 4'd5, 4'd2, 4'd8, 4'd12, 4'd3, 4'd7, 4'd0, 4'd4, 4'd10, 4'd1, 4'd13, 4'd11, 4'd6,
          4'd4, 4'd3, 4'd2, 4'd12, 4'd9, 4'd5, 4'd15, 4'd10, 4'd11, 4'd14, 4'd1, 4'd7, 4'd6, 4'd0, 4'd8, 4'd13},
        '{4'd4, 4'd11, 4'd2, 4'd14, 4'd15, 4'd0, 4'd8, 4'd13, 4'd3, 4'd12, 4'd9, 4'd7, 4'd5, 4'd10, 4'd6, 4'd1,
          4'd13, 4'd0, 4'd11, 4'd7, 4'd4, 4'd9, 4'd1, 4'd10, 4'd14, 4'd3, 4'd5, 4'd12, 4'd2, 4'd15, 4'd8, 4'd6,
          4'd1, 4'd4, 4'd11, 4'd13, 4'd12, 4'd3, 4'd7, 4'd14, 4'd10, 4'd15, 4'd6, 4'd8, 4'd0, 4'd5, 4'd9, 4'd2,
          4'd6, 4'd11, 4'd13, 4'd8, 4'd1, 4'd4, 4'd10, 4'd7, 4'd9, 4'd5, 4'd0, 4'd15, 4'd14, 4'd2, 4'd3, 4'd12},
        '{4'd13, 4'd2, 4'd8, 4'd4, 4'd6, 4'd15, 4'd11, 4'd1, 4'd10, 4'd9, 4'd3, 4'd14, 4'd5, 4'd0, 4'd12, 4'd7,
          4'd1, 4'd15, 4'd13, 4'd8, 4'd10, 4'd3, 4'd7, 4'd4, 4'd12, 4'd5, 4'd6, 4'd11, 4'd0, 4'd14, 4'd9, 4'd2,
          4'd7, 4'd11, 4'd4, 4'd1, 4'd9, 4'd12, 4'd14, 4'd2, 4'd0, 4'd6, 4'd10, 4'd13, 4'd15, 4'd3, 4'd5, 4'd8,
          4'd2, 4'd1, 4'd14, 4'd7, 4'd4, 4'd10, 4'd8, 4'd13, 4'd15, 4'd12, 4'd9, 4'd0, 4'd3, 4'd5, 4'd6, 4'd11}};

    // DES numbers bits from 1 at the MSB; map bit n of a width-bit word to its index.
    function automatic logic [5:0] dbit(input int width, input int n);
        return 6'(width - n);
    endfunction

    function automatic logic [4:0] dbit32(input int n);
        return 5'(32 - n);
    endfunction

    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[dbit(64, i + 1)] = x[dbit(64, IP_T[6'(i)])];
        return y;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[dbit(64, i + 1)] = x[dbit(64, FP_T[6'(i)])];
        return y;
    endfunction

    function automatic logic [55:0] pc1_perm(input logic [63:0] x);
        logic [55:0] y;
        y = '0;
        for (int i = 0; i < 56; i++) y[dbit(56, i + 1)] = x[dbit(64, PC1_T[6'(i)])];
        return y;
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[dbit(48, i + 1)] = x[dbit(56, PC2_T[6'(i)])];
        return y;
    endfunction

    function automatic logic [47:0] e_exp(input logic [31:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[dbit(48, i + 1)] = x[dbit32(E_T[6'(i)])];
        return y;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int i = 0; i < 32; i++) y[dbit32(i + 1)] = x[dbit32(P_T[5'(i)])];
        return y;
    endfunction

    function automatic logic [31:0] s_sub(input logic [47:0] x);
        logic [31:0] y;
        logic [5:0]  b;
        y = '0;
        for (int j = 0; j < 8; j++) begin
            b = x[6'(47 - 6 * j) -: 6];
            y[5'(31 - 4 * j) -: 4] = SBOX[3'(j)][{b[5], b[0], b[4:1]}];
        end
        return y;
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
        case (n)
            2'd1:    return {x[0], x[27:1]};
            2'd2:    return {x[1:0], x[27:2]};
            default: return x;
        endcase
    endfunction

endpackage

// File: rtl/des_decrypt_core_round_f.sv
// DES Feistel function f(R, K) = P(S(E(R) xor K)); purely combinational.
module des_round_f
    import des_pkg::*;
(
    input  logic [31:0] r,
    input  logic [47:0] k,
    output logic [31:0] f
);

    logic [47:0] mixed;

    assign mixed = e_exp(r) ^ k;
    assign f     = p_perm(s_sub(mixed));

endmodule

// File: rtl/des_decrypt_core.sv
// Iterative DES decryption engine, UNROLL Feistel rounds per clock, with
// valid/ready handshakes on the ciphertext and plaintext sides.
//
// state | meaning
// IDLE  | in_ready high, waiting for ciphertext and key
// ROUND | running Feistel rounds, UNROLL per cycle
// DONE  | plaintext held on out_data until out_ready
module des_decrypt_core
    import des_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic [63:0] in_key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        busy
);

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4)) begin : g_bad_unroll
        $error("des_decrypt_core: UNROLL must be 1, 2 or 4");
    end

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [4:0]  cnt_nxt;
    logic [31:0] l_q, r_q;
    logic [27:0] c_q, d_q;

    logic [UNROLL:0][27:0] c_st, d_st;
    logic [UNROLL:0][31:0] l_st, r_st;

    assign c_st[0] = c_q;
    assign d_st[0] = d_q;
    assign l_st[0] = l_q;
    assign r_st[0] = r_q;

    // Stage g computes round cnt_q+g+1; the RS index wraps harmlessly outside ROUND.
    for (genvar g = 0; g < UNROLL; g++) begin : g_round
        logic [1:0]  shift;
        logic [47:0] subkey;
        logic [31:0] f_out;

        assign shift       = RS[4'(cnt_q + 5'(g))];
        assign c_st[g + 1] = rotr28(c_st[g], shift);
        assign d_st[g + 1] = rotr28(d_st[g], shift);
        assign subkey      = pc2_perm({c_st[g + 1], d_st[g + 1]});

        des_round_f u_round_f (
            .r (r_st[g]),
            .k (subkey),
            .f (f_out)
        );

        assign l_st[g + 1] = r_st[g];
        assign r_st[g + 1] = l_st[g] ^ f_out;
    end

    assign cnt_nxt   = cnt_q + 5'(UNROLL);
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_ROUND) || (state_q == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            l_q      <= '0;
            r_q      <= '0;
            c_q      <= '0;
            d_q      <= '0;
            out_data <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        {l_q, r_q} <= ip_perm(in_data);
                        {c_q, d_q} <= pc1_perm(in_key);
                        cnt_q      <= '0;
                        state_q    <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    l_q   <= l_st[UNROLL];
                    r_q   <= r_st[UNROLL];
                    c_q   <= c_st[UNROLL];
                    d_q   <= d_st[UNROLL];
                    cnt_q <= cnt_nxt;
                    if (cnt_nxt == 5'd16) begin
                        out_data <= fp_perm({r_st[UNROLL], l_st[UNROLL]});
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/des_decrypt_core.md
Name: des_decrypt_core

Overview:
Iterative DES decryption engine. It is the inverse-direction counterpart of the team's DES encryption datapath. It accepts a 64-bit ciphertext block and a 64-bit key over a valid/ready handshake, runs 16 Feistel rounds with the key schedule reversed (right rotations), and presents the 64-bit plaintext on a valid/ready output. It sits between the stream deframer and the decompression front end.

Parameters:
UNROLL, 1, Feistel rounds evaluated per clock. Legal values are 1, 2 and 4; any other value is a synthesis error. Round-phase latency = 16/UNROLL cycles.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  ciphertext and key are valid
in_ready  output  1  core can accept a block; high only in IDLE
in_data  input  64  ciphertext; DES bit 1 = [63]
in_key  input  64  DES key; parity bits (8,16,...,64) ignored
out_valid  output  1  plaintext valid
out_ready  input  1  downstream accepts plaintext
out_data  output  64  plaintext; DES bit 1 = [63]
busy  output  1  high in ROUND or DONE

Behaviour:
- Reset: asynchronous, active-high. On assertion: state=IDLE, in_ready=1, out_valid=0, busy=0, out_data=0, round counter=0, L/R/C/D registers=0. Reset mid-operation discards the block; no partial output is produced.
- FSM states: IDLE, ROUND, DONE.
- IDLE: in_ready=1. On an edge with in_valid=1:
  - L||R <= IP(in_data)
  - C||D <= PC1(in_key)
  - round counter <= 0
  - state -> ROUND
- in_data and in_key are sampled only at the accept edge. Later changes are ignored.
- ROUND: each cycle performs UNROLL rounds, i = cnt+1 .. cnt+UNROLL:
  - C||D_i = rotr28(C||D_{i-1}, RS[i]), with RS = 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (so round 1 uses K16 = PC2(C0||D0))
  - K = PC2(C||D_i)
  - L_i = R_{i-1}
  - R_i = L_{i-1} xor f(R_{i-1}, K), where f = P(S(E(R) xor K))
  - counter += UNROLL
- Round-16 edge: out_data <= FP(R16||L16) (final swap included); out_valid <= 1; state -> DONE.
- DONE: out_valid=1 and out_data held stable until an edge with out_ready=1. At that edge: out_valid <= 0, state -> IDLE.
  - out_data keeps its last value after the handshake.
  - in_valid is ignored while in DONE.
- Latency (UNROLL=1): accept at edge T -> out_valid high after edge T+16. Minimum accept-to-accept spacing is 18 cycles (16 + DONE + IDLE).
- Counter width is 5 bits. It never wraps, because the exit test is counter+UNROLL==16.
- Concurrency: in_ready and out_valid are never high together. No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Decomposition:
- Package des_pkg holds:
  - table constants IP, FP, PC1, PC2, E, P, S1..S8
  - the 16-entry right-shift schedule RS
  - state enum typedef
  - bit-numbering helper (DES bit n -> index 64-n or 32-n)
- One combinational sub-module, des_round_f(r[31:0], k[47:0]) -> [31:0], composed of E, XOR, S1..S8 and the existing 32-bit P permutation.
- UNROLL instantiates des_round_f UNROLL times, chained.

Test Plan:
1. Key 133457799BBCDFF1, in_data 85E813540F0AB405 -> out_data 0123456789ABCDEF, out_valid exactly 16 cycles after accept (UNROLL=1).
2. Key 0E329232EA6D0D73, in_data 0000000000000000 -> 8787878787878787. Key 0000000000000000, in_data 8CA64DE9C1B123A7 -> 0000000000000000. Repeat both with UNROLL=2 and 4; latency 8 and 4 cycles respectively.
3. Backpressure: hold out_ready=0 for 20 cycles after out_valid -> out_data stable at 0123456789ABCDEF, in_ready=0 throughout. Raise out_ready -> out_valid drops next edge, in_ready=1.
4. Input isolation: change in_key and in_data every cycle during ROUND; assert in_valid during DONE -> result still matches scenario 1, and no second block is accepted.
5. Async reset at round 7 of a block -> outputs go immediately to reset values (out_valid=0, in_ready=1). Next block (scenario 1 vector) decrypts correctly.
6. Back-to-back: 8 random blocks, each encrypted by a reference model, with random in_valid/out_ready gaps -> every plaintext matches, in order, none dropped or duplicated.
